// File: rtl/mux16_select_bank_pkg.sv
// Shared types and defaults for the registered 16-bit selector bank.
package mux16_select_bank_pkg;

   localparam int unsigned WIDTH = 16;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [2:0]       sel_t;

endpackage : mux16_select_bank_pkg

// File: rtl/mux16_select_bank_mux2_word.sv
// Combinational WIDTH-bit 2:1 selector; the building block of the selection tree.
module mux2_word
   import mux16_select_bank_pkg::*;
#(
   parameter int unsigned WIDTH = mux16_select_bank_pkg::WIDTH
) (
   input  logic             sel_i,
   input  logic [WIDTH-1:0] in0_i,
   input  logic [WIDTH-1:0] in1_i,
   output logic [WIDTH-1:0] out_o
);

   always_comb begin
      out_o = sel_i ? in1_i : in0_i;
   end

endmodule : mux2_word

// File: rtl/mux16_select_bank.sv
// Registered 2-, 4- and 8-way selectors sharing one select code and a 2:1 tree.
module mux16_select_bank
   import mux16_select_bank_pkg::*;
#(
   parameter int unsigned WIDTH = mux16_select_bank_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   input  sel_t             sel,
   output logic [WIDTH-1:0] mux,
   output logic [WIDTH-1:0] mux4,
   output logic [WIDTH-1:0] mux8
);

   logic [WIDTH-1:0] ab_w, cd_w, ef_w, gh_w;
   logic [WIDTH-1:0] abcd_w, efgh_w;
   logic [WIDTH-1:0] mux_d, mux4_d, mux8_d;
   logic [WIDTH-1:0] mux_q, mux4_q, mux8_q;

   // First level: the a/b node doubles as the 2-way result.
   mux2_word #(.WIDTH(WIDTH)) u_ab (.sel_i(sel[0]), .in0_i(a), .in1_i(b), .out_o(ab_w));
   mux2_word #(.WIDTH(WIDTH)) u_cd (.sel_i(sel[0]), .in0_i(c), .in1_i(d), .out_o(cd_w));
   mux2_word #(.WIDTH(WIDTH)) u_ef (.sel_i(sel[0]), .in0_i(e), .in1_i(f), .out_o(ef_w));
   mux2_word #(.WIDTH(WIDTH)) u_gh (.sel_i(sel[0]), .in0_i(g), .in1_i(h), .out_o(gh_w));

   mux2_word #(.WIDTH(WIDTH)) u_abcd (.sel_i(sel[1]), .in0_i(ab_w), .in1_i(cd_w), .out_o(abcd_w));
   mux2_word #(.WIDTH(WIDTH)) u_efgh (.sel_i(sel[1]), .in0_i(ef_w), .in1_i(gh_w), .out_o(efgh_w));

   mux2_word #(.WIDTH(WIDTH)) u_all (.sel_i(sel[2]), .in0_i(abcd_w), .in1_i(efgh_w), .out_o(mux8_d));

   always_comb begin
      mux_d  = ab_w;
      mux4_d = abcd_w;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mux_q  <= '0;
         mux4_q <= '0;
         mux8_q <= '0;
      end else begin
         mux_q  <= mux_d;
         mux4_q <= mux4_d;
         mux8_q <= mux8_d;
      end
   end

   assign mux  = mux_q;
   assign mux4 = mux4_q;
   assign mux8 = mux8_q;

endmodule : mux16_select_bank

// File: tb/tb_mux16_select_bank.sv
// Scoreboard bench for mux16_select_bank: directed vectors, queued expectations, decoupled monitor.
module tb_mux16_select_bank;

   typedef struct {
      logic [15:0] m2;
      logic [15:0] m4;
      logic [15:0] m8;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] a, b, c, d, e, f, g, h;
   logic [2:0]  sel;
   logic [15:0] mux, mux4, mux8;

   exp_t sb_q[$];
   int   checks;
   int   errors;
   bit   stim_done;

   mux16_select_bank #(.WIDTH(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .b    (b),
      .c    (c),
      .d    (d),
      .e    (e),
      .f    (f),
      .g    (g),
      .h    (h),
      .sel  (sel),
      .mux  (mux),
      .mux4 (mux4),
      .mux8 (mux8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of stimulus away from the edge and queue what the next edge must produce.
   task automatic apply(input logic r, input logic [2:0] s, input logic [15:0] ev,
                        input logic [15:0] hv, input logic [15:0] x2,
                        input logic [15:0] x4, input logic [15:0] x8, input string nm);
      exp_t ex;
      @(negedge clk);
      rst_n = r;
      sel   = s;
      e     = ev;
      h     = hv;
      ex.m2 = x2;
      ex.m4 = x4;
      ex.m8 = x8;
      ex.name = nm;
      sb_q.push_back(ex);
   endtask

   task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: outputs are presented after every edge, so pop one expectation per edge.
   initial begin
      exp_t ex;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            ex = sb_q.pop_front();
            cmp({ex.name, ".mux"},  mux,  ex.m2);
            cmp({ex.name, ".mux4"}, mux4, ex.m4);
            cmp({ex.name, ".mux8"}, mux8, ex.m8);
         end
      end
   end

   initial begin
      stim_done = 1'b0;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      sel = 3'd7;
      a = 16'h0000; b = 16'h0001; c = 16'h0002; d = 16'h0003;
      e = 16'h0004; f = 16'h0005; g = 16'h0006; h = 16'hFFFF;

      apply(1'b0, 3'd7, 16'h0004, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, "reset0");
      apply(1'b0, 3'd7, 16'h0004, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, "reset1");

      apply(1'b1, 3'd0, 16'h0004, 16'h0007, 16'h0000, 16'h0000, 16'h0000, "sweep0");
      apply(1'b1, 3'd1, 16'h0004, 16'h0007, 16'h0001, 16'h0001, 16'h0001, "sweep1");
      apply(1'b1, 3'd2, 16'h0004, 16'h0007, 16'h0000, 16'h0002, 16'h0002, "sweep2");
      apply(1'b1, 3'd3, 16'h0004, 16'h0007, 16'h0001, 16'h0003, 16'h0003, "sweep3");
      apply(1'b1, 3'd4, 16'h0004, 16'h0007, 16'h0000, 16'h0000, 16'h0004, "sweep4");
      apply(1'b1, 3'd5, 16'h0004, 16'h0007, 16'h0001, 16'h0001, 16'h0005, "sweep5");
      apply(1'b1, 3'd6, 16'h0004, 16'h0007, 16'h0000, 16'h0002, 16'h0006, "sweep6");
      apply(1'b1, 3'd7, 16'h0004, 16'h0007, 16'h0001, 16'h0003, 16'h0007, "sweep7");
      apply(1'b1, 3'd0, 16'h0004, 16'h0007, 16'h0000, 16'h0000, 16'h0000, "wrap");

      apply(1'b1, 3'd2, 16'h0004, 16'h0007, 16'h0000, 16'h0002, 16'h0002, "lat_pre");
      apply(1'b1, 3'd3, 16'h0004, 16'h0007, 16'h0001, 16'h0003, 16'h0003, "lat_post");

      apply(1'b1, 3'd4, 16'hA5A5, 16'h0007, 16'h0000, 16'h0000, 16'hA5A5, "data_a5");
      apply(1'b1, 3'd4, 16'h5A5A, 16'h0007, 16'h0000, 16'h0000, 16'h5A5A, "data_5a");

      apply(1'b1, 3'd1, 16'h0004, 16'h0007, 16'h0001, 16'h0001, 16'h0001, "mid_pre");
      apply(1'b0, 3'd2, 16'h0004, 16'h0007, 16'h0000, 16'h0000, 16'h0000, "mid_rst");
      apply(1'b1, 3'd3, 16'h0004, 16'h0007, 16'h0001, 16'h0003, 16'h0003, "mid_resume");
      apply(1'b1, 3'd7, 16'h0004, 16'hBEEF, 16'h0001, 16'h0003, 16'hBEEF, "h_pattern");

      stim_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (sb_q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mux16_select_bank
